// File: rtl/difftest_int_wb_serializer_if.sv
// difftest_int_wb_serializer_if: writeback-burst input and difftest-sink output bundle
// master drives the writeback ports and core id; slave (the serializer) drives the sink side and status.
interface difftest_int_wb_serializer_if #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH = 16
);
  logic [NUM_PORTS-1:0]      io_in_valid;
  logic [6*NUM_PORTS-1:0]    io_in_address;
  logic [64*NUM_PORTS-1:0]   io_in_data;
  logic                      io_in_ready;
  logic [7:0]                io_coreid;
  logic                      io_out_valid;
  logic [5:0]                io_out_address;
  logic [63:0]               io_out_data;
  logic [7:0]                io_out_coreid;
  logic [$clog2(DEPTH):0]    io_count;
  logic                      io_overflow;
  logic [15:0]               io_drop_count;
  modport master (
    output io_in_valid, io_in_address, io_in_data, io_coreid,
    input  io_in_ready, io_out_valid, io_out_address, io_out_data, io_out_coreid,
    input  io_count, io_overflow, io_drop_count
  );
  modport slave (
    input  io_in_valid, io_in_address, io_in_data, io_coreid,
    output io_in_ready, io_out_valid, io_out_address, io_out_data, io_out_coreid,
    output io_count, io_overflow, io_drop_count
  );
endinterface

// File: rtl/difftest_int_wb_serializer.sv
// difftest_int_wb_serializer: serializes parallel int writeback events into one-per-cycle difftest sink events
// clock/reset: rising-edge clock, async active-high reset.
// bus (slave): per-port valid/address/data in, io_in_ready, registered sink outputs,
//              FIFO occupancy, sticky overflow and saturating drop counter.
module difftest_int_wb_serializer #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH = 16
) (
  input logic clock,
  input logic reset,
  difftest_int_wb_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [5:0]    r_mem_addr [DEPTH];
  logic [63:0]   r_mem_data [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid, r_overflow;
  logic [5:0]    r_out_addr;
  logic [63:0]   r_out_data;
  logic [7:0]    r_coreid;
  logic [15:0]   r_drop_count;
  logic [AW-1:0] w_off [NUM_PORTS];
  logic [CW-1:0] w_pushes;
  logic          w_ready, w_pop;
  logic [16:0]   w_drop_sum;
  // Each valid port lands at wr_ptr plus the number of valid ports below it.
  always_comb begin
    w_pushes = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_off[i] = r_wr_ptr + w_pushes[AW-1:0];
      w_pushes = w_pushes + CW'(bus.io_in_valid[i]);
    end
  end
  // Ready looks only at the pre-pop count, so a full burst always fits.
  assign w_ready    = r_count <= CW'(DEPTH - NUM_PORTS);
  assign w_pop      = r_count != '0;
  assign w_drop_sum = 17'(r_drop_count) + 17'(w_pushes);
  always_ff @(posedge clock)
    for (int i = 0; i < NUM_PORTS; i++)
      if (w_ready && bus.io_in_valid[i]) begin
        r_mem_addr[w_off[i]] <= bus.io_in_address[6*i +: 6];
        r_mem_data[w_off[i]] <= bus.io_in_data[64*i +: 64];
      end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_coreid     <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_coreid    <= bus.io_coreid;
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_addr <= r_mem_addr[r_rd_ptr];
        r_out_data <= r_mem_data[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + AW'(1);
      end
      if (w_ready) r_wr_ptr <= r_wr_ptr + w_pushes[AW-1:0];
      r_count <= r_count + (w_ready ? w_pushes : '0) - CW'(w_pop);
      if (!w_ready && |bus.io_in_valid) begin
        r_overflow   <= 1'b1;
        r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  assign bus.io_in_ready    = w_ready;
  assign bus.io_out_valid   = r_out_valid;
  assign bus.io_out_address = r_out_addr;
  assign bus.io_out_data    = r_out_data;
  assign bus.io_out_coreid  = r_coreid;
  assign bus.io_count       = r_count;
  assign bus.io_overflow    = r_overflow;
  assign bus.io_drop_count  = r_drop_count;
endmodule

// File: tb/tb_difftest_int_wb_serializer.sv
// tb_difftest_int_wb_serializer: scoreboard bench for the int writeback serializer
module tb_difftest_int_wb_serializer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  difftest_int_wb_serializer_if #(.NUM_PORTS(4), .DEPTH(16)) bus ();
  difftest_int_wb_serializer #(.NUM_PORTS(4), .DEPTH(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  logic [69:0] q [$];
  int m_cnt = 0;
  bit m_valid = 0;
  int m_drop = 0;
  bit m_ovf = 0;
  bit mon_en = 0;
  int rej = 0;
  task automatic cycle(input logic [3:0] v, input logic [23:0] a, input logic [255:0] d);
    int pre;
    int p;
    bit rdy;
    bus.io_in_valid = v;
    bus.io_in_address = a;
    bus.io_in_data = d;
    pre = m_cnt;
    rdy = (16 - m_cnt) >= 4;
    p = 0;
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        p++;
        if (rdy) q.push_back({a[6*i +: 6], d[64*i +: 64]});
      end
    if (!rdy && p > 0) begin
      m_ovf = 1;
      m_drop = (m_drop + p > 65535) ? 65535 : m_drop + p;
      rej++;
    end
    @(posedge clock);
    #1;
    m_cnt = pre + (rdy ? p : 0) - (pre > 0 ? 1 : 0);
    m_valid = pre > 0;
    bus.io_in_valid = '0;
  endtask
  always @(negedge clock)
    if (mon_en) begin
      logic [69:0] e;
      total++;
      if (bus.io_out_valid !== m_valid) begin
        bad++;
        $display("FAIL out_valid got=%0b want=%0b t=%0t", bus.io_out_valid, m_valid, $time);
      end
      total++;
      if (bus.io_count !== 5'(m_cnt)) begin
        bad++;
        $display("FAIL count got=%0d want=%0d t=%0t", bus.io_count, m_cnt, $time);
      end
      if (bus.io_out_valid === 1'b1) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out got addr=%0d data=%h want none", bus.io_out_address, bus.io_out_data);
        end else begin
          e = q.pop_front();
          if ({bus.io_out_address, bus.io_out_data} !== e) begin
            bad++;
            $display("FAIL out_entry got=%0d/%h want=%0d/%h", bus.io_out_address, bus.io_out_data, e[69:64], e[63:0]);
          end
          total++;
          if (bus.io_out_coreid !== bus.io_coreid) begin
            bad++;
            $display("FAIL coreid got=%h want=%h", bus.io_out_coreid, bus.io_coreid);
          end
        end
      end
    end
  task automatic drain();
    int n;
    n = 0;
    while (m_cnt > 0 && n < 300) begin
      cycle('0, '0, '0);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout got cnt=%0d want 0", m_cnt);
    end
    cycle('0, '0, '0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_left got=%0d want=0", q.size());
    end
  endtask
  task automatic test_reset();
    total++;
    if ({bus.io_out_valid, bus.io_out_address, bus.io_out_data, bus.io_out_coreid} !== '0) begin
      bad++;
      $display("FAIL reset_out got=%b/%0d/%h/%h want all 0", bus.io_out_valid, bus.io_out_address, bus.io_out_data, bus.io_out_coreid);
    end
    total++;
    if ({bus.io_count, bus.io_overflow, bus.io_drop_count} !== '0 || bus.io_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_status got cnt=%0d ovf=%b drop=%0d rdy=%b want 0/0/0/1", bus.io_count, bus.io_overflow, bus.io_drop_count, bus.io_in_ready);
    end
  endtask
  task automatic test_single();
    cycle(4'b0001, 24'd5, 256'hDEAD);
    total++;
    if (bus.io_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got=%b want=0", bus.io_out_valid);
    end
    cycle('0, '0, '0);
    total++;
    if (bus.io_out_valid !== 1'b1 || bus.io_out_address !== 6'd5 || bus.io_out_data !== 64'hDEAD || bus.io_out_coreid !== 8'h3C) begin
      bad++;
      $display("FAIL single_out got v=%b a=%0d d=%h c=%h want 1/5/dead/3c", bus.io_out_valid, bus.io_out_address, bus.io_out_data, bus.io_out_coreid);
    end
    cycle('0, '0, '0);
    total++;
    if (bus.io_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_len got=%b want=0", bus.io_out_valid);
    end
  endtask
  task automatic test_burst();
    cycle(4'hF, {6'd4, 6'd3, 6'd2, 6'd1}, {64'h13, 64'h12, 64'h11, 64'h10});
    total++;
    if (bus.io_count !== 5'd4) begin
      bad++;
      $display("FAIL burst_count got=%0d want=4", bus.io_count);
    end
    drain();
  endtask
  task automatic test_sparse();
    cycle(4'b1010, {6'd9, 6'd0, 6'd7, 6'd0}, {64'h99, 64'h0, 64'h77, 64'h0});
    total++;
    if (bus.io_count !== 5'd2) begin
      bad++;
      $display("FAIL sparse_count got=%0d want=2", bus.io_count);
    end
    drain();
  endtask
  task automatic test_overflow();
    rej = 0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (bus.io_in_ready !== ((16 - m_cnt) >= 4)) begin
        bad++;
        $display("FAIL ovf_ready got=%b want=%b cnt=%0d", bus.io_in_ready, (16 - m_cnt) >= 4, m_cnt);
      end
      cycle(4'hF, {6'(4*k+4), 6'(4*k+3), 6'(4*k+2), 6'(4*k+1)}, {64'(k+400), 64'(k+300), 64'(k+200), 64'(k+100)});
    end
    total++;
    if (bus.io_overflow !== 1'b1 || rej == 0) begin
      bad++;
      $display("FAIL ovf_flag got=%b rej=%0d want 1 and rej>0", bus.io_overflow, rej);
    end
    total++;
    if (bus.io_drop_count !== 16'(4 * rej)) begin
      bad++;
      $display("FAIL ovf_drops got=%0d want=%0d", bus.io_drop_count, 4 * rej);
    end
    drain();
  endtask
  task automatic test_wrap();
    for (int k = 0; k < 40; k++) cycle(4'b0100, {6'd0, 6'(k % 63 + 1), 12'd0}, {64'd0, 64'(1000 + k), 128'd0});
    drain();
  endtask
  task automatic test_reset_mid();
    cycle(4'hF, {6'd14, 6'd13, 6'd12, 6'd11}, {64'h24, 64'h23, 64'h22, 64'h21});
    cycle(4'hF, {6'd18, 6'd17, 6'd16, 6'd15}, {64'h28, 64'h27, 64'h26, 64'h25});
    cycle(4'h3, {12'd0, 6'd20, 6'd19}, {128'd0, 64'h30, 64'h29});
    total++;
    if (bus.io_count !== 5'd8) begin
      bad++;
      $display("FAIL mid_count got=%0d want=8", bus.io_count);
    end
    mon_en = 0;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.io_out_valid, bus.io_out_address, bus.io_out_data, bus.io_out_coreid, bus.io_count, bus.io_overflow, bus.io_drop_count} !== '0 || bus.io_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got v=%b a=%0d d=%h cnt=%0d ovf=%b drop=%0d rdy=%b want zeros rdy=1", bus.io_out_valid, bus.io_out_address, bus.io_out_data, bus.io_count, bus.io_overflow, bus.io_drop_count, bus.io_in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    q.delete();
    m_cnt = 0;
    m_valid = 0;
    m_drop = 0;
    m_ovf = 0;
    mon_en = 1;
    repeat (6) cycle('0, '0, '0);
  endtask
  task automatic test_saturation();
    for (int k = 0; k < 22000; k++)
      cycle(4'hF, {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom)},
            {32'($urandom), 32'(k), 32'($urandom), 32'(k), 32'($urandom), 32'(k), 32'($urandom), 32'(k)});
    total++;
    if (bus.io_drop_count !== 16'hFFFF || m_drop != 65535) begin
      bad++;
      $display("FAIL sat_drops got=%h want=ffff model=%0d", bus.io_drop_count, m_drop);
    end
    total++;
    if (bus.io_overflow !== 1'b1) begin
      bad++;
      $display("FAIL sat_ovf got=%b want=1", bus.io_overflow);
    end
    drain();
  endtask
  initial begin
    bus.io_in_valid = '0;
    bus.io_in_address = '0;
    bus.io_in_data = '0;
    bus.io_coreid = 8'h3C;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    mon_en = 1;
    test_single();
    test_burst();
    test_sparse();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
